// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
//   rx_state_e           : receiver FSM state (3-bit encoding)
//   DEFAULT_CLKS_PER_BIT : clocks per bit for 10 MHz / 19200 baud
//   UART_DATA_BITS       : data bits per frame (8N1)
//   IDLE_LEVEL           : line level when idle / stop bit
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StRecover
   } rx_state_e;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 521;
   localparam int unsigned UART_DATA_BITS       = 8;
   localparam logic        IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver.
//   master : receiver side (drives data/valid/status, samples rx_ready)
//   slave  : consumer side (samples data/valid/status, drives rx_ready)
interface uart_rx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] rx_data;
   logic                      rx_valid;
   logic                      rx_ready;
   logic                      rx_frame_err;
   logic                      rx_overrun;
   logic                      rx_busy;

   modport master (
      output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
      input  rx_ready
   );

   modport slave (
      input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy,
      output rx_ready
   );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line, reset to the idle level.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output
module uart_sync2
   import uart_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= IDLE_LEVEL;
         sync_q <= IDLE_LEVEL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready output register.
//   rx_clk : sole clock
//   rst    : synchronous active-high reset
//   rx_in  : asynchronous serial line, idle high, LSB first
//   bus    : rx_data/rx_valid/rx_ready handshake plus rx_frame_err,
//            rx_overrun (one-cycle pulses) and rx_busy
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic      rx_clk,
   input  logic      rst,
   input  logic      rx_in,
   uart_rx_if.master bus
);

   localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] MidCnt  = CntW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [2:0]      LastBit = 3'(UART_DATA_BITS - 1);

   logic                      rx_s;
   rx_state_e                 state_q, state_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic [2:0]                bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      valid_q, valid_d;
   logic                      frame_err_q, frame_err_d;
   logic                      overrun_q, overrun_d;
   logic                      deliver;

   uart_sync2 u_sync (
      .clk_i (rx_clk),
      .rst_i (rst),
      .d_i   (rx_in),
      .q_o   (rx_s)
   );

   // Frame FSM and bit timing.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      deliver     = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rx_s != IDLE_LEVEL) begin
               state_d = StStart;
               cnt_d   = '0;
            end
         end
         StStart: begin
            if (cnt_q == MidCnt) begin
               cnt_d = '0;
               // Line back high at mid start bit: a glitch, not a frame.
               if (rx_s != IDLE_LEVEL) begin
                  state_d   = StData;
                  bit_idx_d = '0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (cnt_q == LastCnt) begin
               cnt_d            = '0;
               shift_d[bit_idx_q] = rx_s;
               bit_idx_d        = bit_idx_q + 3'd1;
               if (bit_idx_q == LastBit) begin
                  state_d = StStop;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StStop: begin
            if (cnt_q == LastCnt) begin
               cnt_d = '0;
               // Deliver at mid stop bit; no wait for the stop bit to end.
               if (rx_s == IDLE_LEVEL) begin
                  deliver = 1'b1;
                  state_d = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StRecover;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StRecover: begin
            // Hold through a break so it yields a single frame error.
            if (rx_s == IDLE_LEVEL) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output register: reload on delivery if free or being consumed, otherwise overrun.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (valid_q && bus.rx_ready) begin
         valid_d = 1'b0;
      end
      if (deliver) begin
         if (!valid_q || bus.rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.rx_data      = data_q;
   assign bus.rx_valid     = valid_q;
   assign bus.rx_frame_err = frame_err_q;
   assign bus.rx_overrun   = overrun_q;
   assign bus.rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected events, a negedge monitor pops them.
module tb_uart_rx;

   localparam int CPB = 16;
   // Edges from the start-bit drive edge to the mid-stop delivery edge:
   // 2 sync + 1 IDLE detect + half start bit + 8 data bits + stop to mid-bit.
   localparam int DelivEdge = 3 + (CPB - 1) / 2 + 1 + 9 * CPB;

   localparam int EvByte = 0;
   localparam int EvFerr = 1;
   localparam int EvOvr  = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } evt_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_in = 1'b1;
   logic mon_en = 1'b0;

   int n_pass = 0;
   int n_total = 0;
   evt_t exp_q[$];

   uart_rx_if u_if ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .rx_clk (clk),
      .rst    (rst),
      .rx_in  (rx_in),
      .bus    (u_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push(input int kind, input logic [7:0] data);
      evt_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Reference rule for a frame sent while the consumer keeps rx_ready high.
   task automatic expect_frame(input logic [7:0] b, input logic stop);
      if (stop) push(EvByte, b);
      else push(EvFerr, 8'h00);
   endtask

   task automatic pop_evt(input int kind, input logic [7:0] data);
      evt_t e;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL unexpected_event: got kind %0d data %0h, expected none", kind, data);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         if (e.kind == EvByte) check("event_data", data, e.data);
      end
   endtask

   // Drives one frame; call just after a rising edge. Line is left at the stop level.
   task automatic send(input logic [7:0] b, input logic stop);
      rx_in = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      rx_in = stop;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: samples mid-cycle; prev ready is the value present at the following edge.
   initial begin
      logic       p_valid, p_ready, p_rst;
      logic [7:0] p_data;
      logic       new_byte;
      p_valid = 1'b0;
      p_ready = 1'b0;
      p_rst   = 1'b1;
      p_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            new_byte = u_if.rx_valid && (!p_valid || p_ready);
            if (new_byte) pop_evt(EvByte, u_if.rx_data);
            if (u_if.rx_frame_err) pop_evt(EvFerr, 8'h00);
            if (u_if.rx_overrun) pop_evt(EvOvr, 8'h00);
            if (u_if.rx_frame_err || u_if.rx_overrun)
               check("err_exclusive", u_if.rx_frame_err & u_if.rx_overrun, 0);
            if (p_valid && !p_ready && !p_rst) begin
               check("valid_hold", u_if.rx_valid, 1);
               check("data_stable", u_if.rx_data, p_data);
            end
         end
         p_valid = u_if.rx_valid;
         p_ready = u_if.rx_ready;
         p_rst   = rst;
         p_data  = u_if.rx_data;
      end
   end

   initial begin
      logic [7:0] b;
      logic       stop;
      u_if.rx_ready = 1'b1;
      cycles(5);
      check("rst_valid", u_if.rx_valid, 0);
      check("rst_busy", u_if.rx_busy, 0);
      check("rst_data", u_if.rx_data, 8'h00);
      check("rst_ferr", u_if.rx_frame_err, 0);
      check("rst_ovr", u_if.rx_overrun, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      cycles(5);

      // Clean byte, consumer always ready.
      expect_frame(8'hA5, 1'b1);
      send(8'hA5, 1'b1);
      cycles(20);

      // Short low glitch: false start rejected.
      rx_in = 1'b0;
      cycles(4);
      rx_in = 1'b1;
      cycles(1);
      check("glitch_busy_hi", u_if.rx_busy, 1);
      cycles(7);
      check("glitch_busy_lo", u_if.rx_busy, 0);
      cycles(10);

      // Bad stop bit followed by a held break.
      expect_frame(8'h3C, 1'b0);
      send(8'h3C, 1'b0);
      cycles(40);
      check("break_busy", u_if.rx_busy, 1);
      rx_in = 1'b1;
      cycles(6);
      check("break_idle", u_if.rx_busy, 0);
      cycles(10);

      // Overrun: two bytes, consumer not ready.
      u_if.rx_ready = 1'b0;
      push(EvByte, 8'h11);
      send(8'h11, 1'b1);
      push(EvOvr, 8'h00);
      send(8'h22, 1'b1);
      cycles(5);
      check("ovr_data", u_if.rx_data, 8'h11);
      check("ovr_valid", u_if.rx_valid, 1);
      u_if.rx_ready = 1'b1;
      cycles(1);
      check("ovr_consumed", u_if.rx_valid, 0);
      u_if.rx_ready = 1'b0;
      cycles(5);

      // Consume exactly on the delivery edge of the next byte.
      push(EvByte, 8'h7E);
      send(8'h7E, 1'b1);
      cycles(3);
      push(EvByte, 8'h81);
      fork
         send(8'h81, 1'b1);
         begin
            repeat (DelivEdge - 1) @(posedge clk);
            #1 u_if.rx_ready = 1'b1;
            @(posedge clk);
            #1 u_if.rx_ready = 1'b0;
         end
      join
      cycles(3);
      check("edge_data", u_if.rx_data, 8'h81);
      check("edge_valid", u_if.rx_valid, 1);
      u_if.rx_ready = 1'b1;
      cycles(1);
      check("edge_consumed", u_if.rx_valid, 0);
      cycles(5);

      // Reset in the middle of a frame abandons it.
      fork
         send(8'hFF, 1'b1);
         begin
            cycles(60);
            rst = 1'b1;
            cycles(1);
            check("midrst_busy", u_if.rx_busy, 0);
            check("midrst_valid", u_if.rx_valid, 0);
            check("midrst_data", u_if.rx_data, 8'h00);
            cycles(1);
            rst = 1'b0;
         end
      join
      cycles(5);
      expect_frame(8'h0F, 1'b1);
      send(8'h0F, 1'b1);
      cycles(5);

      // Randomised frames, some with a bad stop bit.
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         expect_frame(b, stop);
         send(b, stop);
         rx_in = 1'b1;
         cycles($urandom_range(3, CPB));
      end

      // Bounded drain of outstanding expectations.
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cycles(1);
      check("queue_drained", exp_q.size(), 0);
      cycles(5);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
